pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 13 +
 rtl/pc_sequencer_next.sv | 39 +++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared opcode constants and FSM state encoding for the PC sequencer.
package pc_sequencer_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_VECTOR = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_next.sv
// Combinational next-address calculation: sequential, branch target, branch
// decision and the instruction-selected next PC.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 7
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] regB,
  input  logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] seq,
  output logic [ADDR_W-1:0] beq_t,
  output logic              taken,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] imm_ext_s;

  assign imm_ext_s = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign seq       = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign beq_t     = seq + imm_ext_s;
  assign taken     = (op == OP_BEQ) && (alu_out == regB);

  // Select the address the current instruction would continue at.
  always_comb begin
    next_pc = seq;
    if (op == OP_JALR) begin
      next_pc = alu_out;
    end else if (taken) begin
      next_pc = beq_t;
    end else begin
      next_pc = seq;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: RUN/VECTOR/HALT FSM, PC/EPC registers and the
// halt > interrupt > reti > jalr > beq > sequential priority chain.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                IMM_W     = 7,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(16'h0010)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] regB,
  input  logic [IMM_W-1:0]  imm,
  input  logic              irq_req,
  input  logic              reti,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic              irq_ack,
  output logic              in_isr,
  output logic              halted
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [ADDR_W-1:0] epc_nxt_s;
  logic              in_isr_nxt_s;
  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] beq_t_s;
  logic              taken_s;
  logic [ADDR_W-1:0] next_s;
  logic              unused_ok_s;

  pc_next_calc #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_next (
    .pc      (pc),
    .op      (op),
    .alu_out (alu_out),
    .regB    (regB),
    .imm     (imm),
    .seq     (seq_s),
    .beq_t   (beq_t_s),
    .taken   (taken_s),
    .next_pc (next_s)
  );

  // Branch details are folded into next_s; kept visible for debug only.
  assign unused_ok_s = &{1'b0, beq_t_s, taken_s};

  assign irq_ack = (state_r == ST_VECTOR);

  // Next-state and register updates; stall only freezes RUN, never VECTOR.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc;
    epc_nxt_s    = epc;
    in_isr_nxt_s = in_isr;
    case (state_r)
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_nxt_s = ST_HALT;
          end else if (irq_req && !in_isr) begin
            state_nxt_s = ST_VECTOR;
            epc_nxt_s   = next_s;
          end else if (reti && in_isr) begin
            pc_nxt_s     = epc;
            in_isr_nxt_s = 1'b0;
          end else begin
            pc_nxt_s = next_s;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_VECTOR: begin
        pc_nxt_s     = IRQ_VEC;
        in_isr_nxt_s = 1'b1;
        state_nxt_s  = ST_RUN;
      end
      ST_HALT: begin
        if (irq_req && !in_isr) begin
          state_nxt_s = ST_VECTOR;
          epc_nxt_s   = seq_s;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State and architectural registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
      pc      <= RESET_VEC;
      epc     <= {ADDR_W{1'b0}};
      in_isr  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc      <= pc_nxt_s;
      epc     <= epc_nxt_s;
      in_isr  <= in_isr_nxt_s;
      halted  <= (state_nxt_s == ST_HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam int ADDR_W = 16;
  localparam int IMM_W  = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] alu_out = 16'h0;
  logic [15:0] regB = 16'h0;
  logic [6:0]  imm = 7'h0;
  logic        irq_req = 1'b0;
  logic        reti = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] pc;
  logic [15:0] epc;
  logic        irq_ack;
  logic        in_isr;
  logic        halted;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .IMM_W     (IMM_W),
    .RESET_VEC (16'h0000),
    .IRQ_VEC   (16'h0010)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .op      (op),
    .alu_out (alu_out),
    .regB    (regB),
    .imm     (imm),
    .irq_req (irq_req),
    .reti    (reti),
    .halt    (halt),
    .pc      (pc),
    .epc     (epc),
    .irq_ack (irq_ack),
    .in_isr  (in_isr),
    .halted  (halted)
  );

  // Model: architectural values plus "the next edge is the vector entry".
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] epc;
    logic        in_isr;
    logic        halted;
    logic        vec_pending;
  } model_t;

  model_t m;

  function automatic logic [15:0] target_of(logic [15:0] cur);
    int simm;
    int t;
    simm = imm[6] ? int'(imm) - 128 : int'(imm);
    if (op == 3'd7) begin
      t = int'(alu_out);
    end else if (op == 3'd6 && alu_out == regB) begin
      t = int'(cur) + 1 + simm;
    end else begin
      t = int'(cur) + 1;
    end
    return t[15:0];
  endfunction

  function automatic model_t model_step(model_t s);
    model_t n;
    int w;
    n = s;
    if (s.vec_pending) begin
      n.pc = 16'h0010;
      n.in_isr = 1'b1;
      n.vec_pending = 1'b0;
    end else if (s.halted) begin
      if (irq_req && !s.in_isr) begin
        w = int'(s.pc) + 1;
        n.halted = 1'b0;
        n.vec_pending = 1'b1;
        n.epc = w[15:0];
      end
    end else if (!stall) begin
      if (halt) begin
        n.halted = 1'b1;
      end else if (irq_req && !s.in_isr) begin
        n.vec_pending = 1'b1;
        n.epc = target_of(s.pc);
      end else if (reti && s.in_isr) begin
        n.pc = s.epc;
        n.in_isr = 1'b0;
      end else begin
        n.pc = target_of(s.pc);
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic st, input logic [2:0] o, input logic [15:0] a,
                     input logic [15:0] b, input logic [6:0] im,
                     input logic iq, input logic rt, input logic hl);
    stall = st; op = o; alu_out = a; regB = b; imm = im;
    irq_req = iq; reti = rt; halt = hl;
    @(negedge clk);
  endtask

  // Advance the reference model on the same events as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '{pc: 16'h0000, epc: 16'h0000, in_isr: 1'b0, halted: 1'b0, vec_pending: 1'b0};
    end else begin
      m <= model_step(m);
    end
  end

  // Compare every observable output against the model away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_pc", pc, m.pc);
      chk("mdl_epc", epc, m.epc);
      chk("mdl_in_isr", 16'(in_isr), 16'(m.in_isr));
      chk("mdl_halted", 16'(halted), 16'(m.halted));
      chk("mdl_irq_ack", 16'(irq_ack), 16'(m.vec_pending));
    end
  end

  initial begin
    logic [15:0] a_r;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk("rst_in_isr", 16'(in_isr), 16'h0);
    chk("rst_irq_ack", 16'(irq_ack), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk_en = 1'b1;
    reset = 1'b0;

    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("seq1", pc, 16'h0001);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("seq2", pc, 16'h0002);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("seq3", pc, 16'h0003);

    cyc(1'b0, 3'd7, 16'h0005, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd6, 16'h0007, 16'h0007, 7'h7E, 1'b0, 1'b0, 1'b0); chk("beq_taken", pc, 16'h0004);
    cyc(1'b0, 3'd7, 16'h0005, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd6, 16'h0007, 16'h0008, 7'h7E, 1'b0, 1'b0, 1'b0); chk("beq_not_taken", pc, 16'h0006);

    cyc(1'b0, 3'd7, 16'hFFFF, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("seq_wrap", pc, 16'h0000);
    cyc(1'b0, 3'd7, 16'h1234, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("jalr", pc, 16'h1234);

    cyc(1'b0, 3'd7, 16'h0020, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd7, 16'h0040, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0);
    chk("irq_epc", epc, 16'h0040); chk("irq_pc_hold", pc, 16'h0020);
    chk("irq_ack_hi", 16'(irq_ack), 16'h1);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0);
    chk("vec_pc", pc, 16'h0010); chk("vec_in_isr", 16'(in_isr), 16'h1);
    chk("irq_ack_lo", 16'(irq_ack), 16'h0);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0); chk("no_nest", pc, 16'h0011);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b1, 1'b0);
    chk("reti_pc", pc, 16'h0040); chk("reti_in_isr", 16'(in_isr), 16'h0);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0);
    chk("reentry_ack", 16'(irq_ack), 16'h1); chk("reentry_epc", epc, 16'h0041);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b1, 1'b0); chk("reti2_pc", pc, 16'h0041);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b1, 1'b0); chk("reti_ignored", pc, 16'h0042);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b1);
      chk("stall_pc", pc, 16'h0042); chk("stall_halted", 16'(halted), 16'h0);
      chk("stall_ack", 16'(irq_ack), 16'h0);
    end
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b1);
    chk("halt_enter", 16'(halted), 16'h1); chk("halt_pc", pc, 16'h0042);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0);
    chk("wake_ack", 16'(irq_ack), 16'h1); chk("wake_epc", epc, 16'h0043);
    chk("wake_halted", 16'(halted), 16'h0);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("wake_vec_pc", pc, 16'h0010);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0);
      chk("isr_halt_locked", 16'(halted), 16'h1); chk("isr_halt_noack", 16'(irq_ack), 16'h0);
    end

    reset = 1'b1; #1;
    chk("rst_halt_pc", pc, 16'h0000); chk("rst_halt_halted", 16'(halted), 16'h0);
    @(negedge clk); reset = 1'b0;
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0); chk("post_rst_seq", pc, 16'h0001);
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0, 1'b0); chk("pre_rst_vec_ack", 16'(irq_ack), 16'h1);
    #2 reset = 1'b1; #1;
    chk("rst_vec_pc", pc, 16'h0000); chk("rst_vec_in_isr", 16'(in_isr), 16'h0);
    chk("rst_vec_ack", 16'(irq_ack), 16'h0);
    @(negedge clk); reset = 1'b0;
    cyc(1'b0, 3'd0, 16'h0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    chk("after_rst_pc", pc, 16'h0001); chk("after_rst_ack", 16'(irq_ack), 16'h0);
    chk("after_rst_in_isr", 16'(in_isr), 16'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(149) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      a_r = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(3));
      cyc($urandom_range(7) == 0, 3'($urandom_range(7)), a_r, 16'($urandom_range(3)),
          7'($urandom), $urandom_range(5) == 0, $urandom_range(4) == 0,
          $urandom_range(24) == 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
